// File: rtl/o_upd_ctrl.sv
// o_upd_ctrl: sequences the online-softmax O-rescale unit over the KV blocks
// of one Q row tile. It keeps the running m/l row statistics, launches the
// update unit for every block except the first, and passes rescale
// coefficients to the O accumulator.

// Per-row statistic registers: new block stats, committed old stats, finals.
module o_upd_row #(
  parameter int D_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_new,
  input  logic             commit,
  input  logic             ld_fin,
  input  logic [D_W-1:0]   mi_in,
  input  logic [2*D_W-1:0] li_in,
  output logic [D_W-1:0]   mi_old,
  output logic [2*D_W-1:0] li_old,
  output logic [D_W-1:0]   mi_new,
  output logic [2*D_W-1:0] li_new,
  output logic [D_W-1:0]   mi_fin,
  output logic [2*D_W-1:0] li_fin
);

  // Plain register moves: latch on accept, shift new->old/fin on commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mi_old <= '0;
      li_old <= '0;
      mi_new <= '0;
      li_new <= '0;
      mi_fin <= '0;
      li_fin <= '0;
    end else begin
      if (ld_new) begin
        mi_new <= mi_in;
        li_new <= li_in;
      end
      if (commit) begin
        mi_old <= mi_new;
        li_old <= li_new;
      end
      if (ld_fin) begin
        mi_fin <= mi_new;
        li_fin <= li_new;
      end
    end
  end

endmodule

module o_upd_ctrl #(
  parameter int D_W     = 8,
  parameter int TIL     = 16,
  parameter int NUM_BLK = 4,
  parameter int TMO     = 64
) (
  input  logic                          I_CLK,
  input  logic                          I_RST_N,
  input  logic                          I_START,
  input  logic                          I_BLK_VLD,
  output logic                          O_BLK_RDY,
  input  logic [TIL-1:0][D_W-1:0]       I_MI_BLK,
  input  logic [TIL-1:0][2*D_W-1:0]     I_LI_BLK,
  output logic                          O_UPD_ENA,
  output logic [TIL-1:0][2*D_W-1:0]     O_LI_OLD,
  output logic [TIL-1:0][D_W-1:0]       O_MI_OLD,
  output logic [TIL-1:0][2*D_W-1:0]     O_LI_NEW,
  output logic [TIL-1:0][D_W-1:0]       O_MI_NEW,
  input  logic                          I_UPD_VLD,
  input  logic [TIL-1:0][D_W-1:0]       I_UPD_COEF,
  output logic                          O_COEF_VLD,
  input  logic                          I_COEF_RDY,
  output logic [TIL-1:0][D_W-1:0]       O_COEF,
  output logic                          O_FIRST,
  output logic                          O_LAST,
  output logic                          O_DONE,
  output logic [TIL-1:0][D_W-1:0]       O_MI_FIN,
  output logic [TIL-1:0][2*D_W-1:0]     O_LI_FIN,
  output logic                          O_ERR
);

  localparam int CNT_W = $clog2(NUM_BLK) + 1;
  localparam int TMO_W = $clog2(TMO + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_HOLD, S_DONE} state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] blk_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             start_ok, accept, hshk, first_blk, last_blk, tmo_hit;

  assign start_ok  = I_START && (state == S_IDLE || state == S_DONE);
  assign accept    = (state == S_WAIT) && I_BLK_VLD;
  assign hshk      = (state == S_HOLD) && I_COEF_RDY;
  assign first_blk = (blk_cnt == '0);
  assign last_blk  = (blk_cnt == CNT_W'(NUM_BLK - 1));
  assign tmo_hit   = (state == S_RUN) && !I_UPD_VLD && (tmo_cnt == TMO_W'(TMO - 1));

  // Outputs decode straight from the state register, so they are glitch-free
  // and all zero while the state is IDLE.
  assign O_BLK_RDY  = (state == S_WAIT);
  assign O_UPD_ENA  = (state == S_RUN);
  assign O_COEF_VLD = (state == S_HOLD);
  assign O_FIRST    = (state == S_HOLD) && first_blk;
  assign O_LAST     = (state == S_HOLD) && last_blk;
  assign O_DONE     = (state == S_DONE);

  // State register.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next-state logic; the first block bypasses the update unit entirely.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (I_START) nxt = S_WAIT;
      S_WAIT:         if (I_BLK_VLD) nxt = first_blk ? S_HOLD : S_RUN;
      S_RUN: begin
        if (I_UPD_VLD)    nxt = S_HOLD;
        else if (tmo_hit) nxt = S_IDLE;
      end
      S_HOLD:         if (I_COEF_RDY) nxt = last_blk ? S_DONE : S_WAIT;
      default:        nxt = S_IDLE;
    endcase
  end

  // Block counter (saturates at the last block), timeout counter, error
  // flag and the registered coefficient word.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      blk_cnt <= '0;
      tmo_cnt <= '0;
      O_ERR   <= 1'b0;
      O_COEF  <= '0;
    end else begin
      if (start_ok) begin
        blk_cnt <= '0;
        O_ERR   <= 1'b0;
      end else if (hshk && !last_blk) begin
        blk_cnt <= blk_cnt + 1'b1;
      end
      if (accept)
        tmo_cnt <= '0;
      else if (state == S_RUN && !I_UPD_VLD)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)
        O_ERR <= 1'b1;
      if (accept && first_blk)
        O_COEF <= '0;
      else if (state == S_RUN && I_UPD_VLD)
        O_COEF <= I_UPD_COEF;
    end
  end

  for (genvar r = 0; r < TIL; r++) begin : g_row
    o_upd_row #(.D_W(D_W)) u_row (
      .clk    (I_CLK),
      .rst_n  (I_RST_N),
      .ld_new (accept),
      .commit (hshk),
      .ld_fin (hshk && last_blk),
      .mi_in  (I_MI_BLK[r]),
      .li_in  (I_LI_BLK[r]),
      .mi_old (O_MI_OLD[r]),
      .li_old (O_LI_OLD[r]),
      .mi_new (O_MI_NEW[r]),
      .li_new (O_LI_NEW[r]),
      .mi_fin (O_MI_FIN[r]),
      .li_fin (O_LI_FIN[r])
    );
  end

endmodule

// File: tb/tb_o_upd_ctrl.sv
// Randomized bench for o_upd_ctrl: a transaction-level model tracks the
// stats of every block and the expected handshake timeline of each tile.
module tb_o_upd_ctrl;

  localparam int D_W = 8;
  localparam int TIL = 16;
  localparam int NB  = 4;
  localparam int TMO = 64;
  localparam int MW  = TIL * D_W;
  localparam int LW  = TIL * 2 * D_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main DUT (NUM_BLK=4)
  logic                      start, blk_vld, blk_rdy, upd_ena, upd_vld;
  logic                      coef_vld, coef_rdy, first, last, done, err;
  logic [TIL-1:0][D_W-1:0]   mi_blk, mi_old, mi_new, upd_coef, coef, mi_fin;
  logic [TIL-1:0][2*D_W-1:0] li_blk, li_old, li_new, li_fin;

  // single-block DUT (NUM_BLK=1)
  logic                      s_start, s_blk_vld, s_blk_rdy, s_upd_ena, s_upd_vld;
  logic                      s_coef_vld, s_coef_rdy, s_first, s_last, s_done, s_err;
  logic [TIL-1:0][D_W-1:0]   s_mi_blk, s_mi_old, s_mi_new, s_upd_coef, s_coef, s_mi_fin;
  logic [TIL-1:0][2*D_W-1:0] s_li_blk, s_li_old, s_li_new, s_li_fin;

  o_upd_ctrl #(.D_W(D_W), .TIL(TIL), .NUM_BLK(NB), .TMO(TMO)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_BLK_VLD(blk_vld),
    .O_BLK_RDY(blk_rdy), .I_MI_BLK(mi_blk), .I_LI_BLK(li_blk),
    .O_UPD_ENA(upd_ena), .O_LI_OLD(li_old), .O_MI_OLD(mi_old),
    .O_LI_NEW(li_new), .O_MI_NEW(mi_new), .I_UPD_VLD(upd_vld),
    .I_UPD_COEF(upd_coef), .O_COEF_VLD(coef_vld), .I_COEF_RDY(coef_rdy),
    .O_COEF(coef), .O_FIRST(first), .O_LAST(last), .O_DONE(done),
    .O_MI_FIN(mi_fin), .O_LI_FIN(li_fin), .O_ERR(err)
  );

  o_upd_ctrl #(.D_W(D_W), .TIL(TIL), .NUM_BLK(1), .TMO(TMO)) dut1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(s_start), .I_BLK_VLD(s_blk_vld),
    .O_BLK_RDY(s_blk_rdy), .I_MI_BLK(s_mi_blk), .I_LI_BLK(s_li_blk),
    .O_UPD_ENA(s_upd_ena), .O_LI_OLD(s_li_old), .O_MI_OLD(s_mi_old),
    .O_LI_NEW(s_li_new), .O_MI_NEW(s_mi_new), .I_UPD_VLD(s_upd_vld),
    .I_UPD_COEF(s_upd_coef), .O_COEF_VLD(s_coef_vld), .I_COEF_RDY(s_coef_rdy),
    .O_COEF(s_coef), .O_FIRST(s_first), .O_LAST(s_last), .O_DONE(s_done),
    .O_MI_FIN(s_mi_fin), .O_LI_FIN(s_li_fin), .O_ERR(s_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: committed stats of the most recent block
  logic [MW-1:0] m_prev;
  logic [LW-1:0] l_prev;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] rnd_m();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] rnd_l();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".ena"}, upd_ena, 0);
    chk({tag, ".rdy"}, blk_rdy, 0);
    chk({tag, ".cvld"}, coef_vld, 0);
    chk({tag, ".first"}, first, 0);
    chk({tag, ".last"}, last, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".coef"}, coef, 0);
    chk({tag, ".mold"}, mi_old, 0);
    chk({tag, ".lold"}, li_old, 0);
    chk({tag, ".mnew"}, mi_new, 0);
    chk({tag, ".lnew"}, li_new, 0);
    chk({tag, ".mfin"}, mi_fin, 0);
    chk({tag, ".lfin"}, li_fin, 0);
  endtask

  task automatic start_tile();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start.rdy", blk_rdy, 1);
    chk("start.err", err, 0);
    chk("start.done", done, 0);
  endtask

  // One block: accept, k-cycle unit latency (skipped for block 0), then
  // HOLD for dly cycles with junk on ignored inputs before the handshake.
  task automatic run_block(input int b, input int k, input int dly, input bit start_in_run,
                           input logic [MW-1:0] m_in, input logic [LW-1:0] l_in);
    logic [MW-1:0] exp_coef;
    logic [MW-1:0] c_r;
    chk("blk.rdy", blk_rdy, 1);
    blk_vld = 1'b1;
    mi_blk  = m_in;
    li_blk  = l_in;
    @(negedge clk);
    blk_vld = 1'b0;
    mi_blk  = rnd_m();
    li_blk  = rnd_l();
    exp_coef = '0;
    if (b > 0) begin
      c_r = rnd_m();
      for (int c = 1; c <= k; c++) begin
        chk("run.ena", upd_ena, 1);
        chk("run.rdy", blk_rdy, 0);
        if (c == 1) begin
          chk("run.mold", mi_old, m_prev);
          chk("run.lold", li_old, l_prev);
          chk("run.mnew", mi_new, m_in);
          chk("run.lnew", li_new, l_in);
          if (start_in_run) start = 1'b1;
        end
        if (c == k) begin
          upd_vld  = 1'b1;
          upd_coef = c_r;
        end
        @(negedge clk);
        start = 1'b0;
      end
      upd_vld  = 1'b0;
      upd_coef = rnd_m();
      exp_coef = c_r;
    end
    chk("hold.ena", upd_ena, 0);
    chk("hold.cvld", coef_vld, 1);
    chk("hold.first", first, b == 0);
    chk("hold.last", last, b == NB - 1);
    chk("hold.coef", coef, exp_coef);
    chk("hold.mnew", mi_new, m_in);
    for (int d = 0; d < dly; d++) begin
      blk_vld  = 1'b1;
      upd_vld  = 1'b1;
      upd_coef = rnd_m();
      @(negedge clk);
      chk("wait.cvld", coef_vld, 1);
      chk("wait.coef", coef, exp_coef);
      chk("wait.rdy", blk_rdy, 0);
      chk("wait.mold", mi_old, m_prev);
      chk("wait.mnew", mi_new, m_in);
    end
    blk_vld  = 1'b0;
    upd_vld  = 1'b0;
    coef_rdy = 1'b1;
    @(negedge clk);
    coef_rdy = 1'b0;
    m_prev = m_in;
    l_prev = l_in;
    chk("commit.mold", mi_old, m_prev);
    chk("commit.lold", li_old, l_prev);
    chk("commit.cvld", coef_vld, 0);
    if (b == NB - 1) begin
      chk("fin.done", done, 1);
      chk("fin.m", mi_fin, m_prev);
      chk("fin.l", li_fin, l_prev);
    end else begin
      chk("next.done", done, 0);
    end
  endtask

  task automatic rand_tile();
    for (int b = 0; b < NB; b++)
      run_block(b, $urandom_range(1, 8), $urandom_range(0, 3), 1'b0, rnd_m(), rnd_l());
  endtask

  initial begin
    rst_n = 1'b0;
    {start, blk_vld, upd_vld, coef_rdy} = '0;
    mi_blk = '0; li_blk = '0; upd_coef = '0;
    {s_start, s_blk_vld, s_upd_vld, s_coef_rdy} = '0;
    s_mi_blk = '0; s_li_blk = '0; s_upd_coef = '0;
    m_prev = '0; l_prev = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // directed tile: latency 5, RDY=1 except a 7-cycle stall on the last block
    start_tile();
    run_block(0, 5, 0, 1'b0, rnd_m(), rnd_l());
    run_block(1, 5, 0, 1'b0, {TIL{8'h08}}, {TIL{16'h0100}});
    run_block(2, 5, 0, 1'b1, {TIL{8'h10}}, {TIL{16'h0200}});
    run_block(3, 5, 7, 1'b0, rnd_m(), rnd_l());
    @(negedge clk);
    chk("done.hold", done, 1);
    chk("done.rdy", blk_rdy, 0);

    // randomized tiles
    for (int t = 0; t < 3; t++) begin
      start_tile();
      rand_tile();
    end

    // unit never answers: timeout TMO cycles after ENA rises
    start_tile();
    run_block(0, 1, 0, 1'b0, rnd_m(), rnd_l());
    blk_vld = 1'b1;
    mi_blk  = rnd_m();
    li_blk  = rnd_l();
    @(negedge clk);
    blk_vld = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      chk("tmo.ena", upd_ena, 1);
      if (c == TMO) chk("tmo.err_early", err, 0);
      @(negedge clk);
    end
    chk("tmo.err", err, 1);
    chk("tmo.ena_off", upd_ena, 0);
    chk("tmo.rdy", blk_rdy, 0);
    chk("tmo.cvld", coef_vld, 0);
    chk("tmo.mold", mi_old, m_prev);
    @(negedge clk);
    chk("tmo.sticky", err, 1);
    start_tile();
    rand_tile();

    // reset in the middle of RUN
    start_tile();
    run_block(0, 1, 0, 1'b0, rnd_m(), rnd_l());
    blk_vld = 1'b1;
    @(negedge clk);
    blk_vld = 1'b0;
    chk("mid.ena", upd_ena, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero("midrst");
    m_prev = '0;
    l_prev = '0;
    start_tile();
    rand_tile();

    // NUM_BLK=1: one handshake, FIRST=LAST=1, coef=0, no ENA
    begin
      logic [MW-1:0] sm;
      logic [LW-1:0] sl;
      sm = rnd_m();
      sl = rnd_l();
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      chk("one.rdy", s_blk_rdy, 1);
      s_blk_vld = 1'b1;
      s_mi_blk  = sm;
      s_li_blk  = sl;
      @(negedge clk);
      s_blk_vld = 1'b0;
      chk("one.cvld", s_coef_vld, 1);
      chk("one.first", s_first, 1);
      chk("one.last", s_last, 1);
      chk("one.coef", s_coef, 0);
      chk("one.ena", s_upd_ena, 0);
      s_coef_rdy = 1'b1;
      @(negedge clk);
      s_coef_rdy = 1'b0;
      chk("one.done", s_done, 1);
      chk("one.ena2", s_upd_ena, 0);
      chk("one.mfin", s_mi_fin, sm);
      chk("one.lfin", s_li_fin, sl);
      chk("one.err", s_err, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
